// File: rtl/qdiv_pkg.sv
// qdiv_pkg: shared types and constants for the sequential sign-magnitude divider
package qdiv_pkg;
  localparam int N = 32;
  localparam int Q = 15;
  localparam int ITER = N + Q - 1;
  localparam int CNT_W = $clog2(ITER);
  localparam logic [N-2:0] MAX_MAG = '1;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
endpackage

// File: rtl/qdiv_seq.sv
// qdiv_seq: radix-2 restoring sign-magnitude Q-format divider, one quotient bit per clock
module qdiv_seq
  import qdiv_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic         overflow,
  output logic         div_by_zero
);
  state_t state, state_nx;
  logic [ITER-1:0] sr, q_nx;
  logic [ITER-2:0] qr;
  logic [N-1:0] r_sh;
  logic [N-2:0] r, r_nx, dv, mag;
  logic [CNT_W-1:0] cnt;
  logic sgn, accept, zero_div, last, ge, ovf;
  assign accept = start && state != CALC;
  assign zero_div = divisor[N-2:0] == '0;
  assign last = state == CALC && cnt == '0;
  assign busy = state == CALC;
  assign done = state == DONE;
  // remainder always stays below the divisor, so N-1 bits hold it between steps
  assign r_sh = {r, sr[ITER-1]};
  assign ge = r_sh >= {1'b0, dv};
  assign r_nx = ge ? (N-1)'(r_sh - {1'b0, dv}) : r_sh[N-2:0];
  assign q_nx = {qr, ge};
  assign ovf = |q_nx[ITER-1:N-1];
  assign mag = ovf ? MAX_MAG : q_nx[N-2:0];
  always_comb begin
    state_nx = accept ? (zero_div ? DONE : CALC) : last ? DONE : state == DONE ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sgn <= 1'b0;
      dv <= '0;
      sr <= '0;
      r <= '0;
      qr <= '0;
      cnt <= '0;
      quotient <= '0;
      overflow <= 1'b0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      sgn <= dividend[N-1] ^ divisor[N-1];
      dv <= divisor[N-2:0];
      sr <= {dividend[N-2:0], {Q{1'b0}}};
      r <= '0;
      cnt <= CNT_W'(ITER - 1);
      if (zero_div) begin
        quotient <= {dividend[N-1] ^ divisor[N-1], MAX_MAG};
        overflow <= 1'b0;
        div_by_zero <= 1'b1;
      end
    end else if (busy) begin
      sr <= {sr[ITER-2:0], 1'b0};
      r <= r_nx;
      qr <= q_nx[ITER-2:0];
      cnt <= cnt - 1'b1;
      if (last) begin
        quotient <= {sgn && mag != '0, mag};
        overflow <= ovf;
        div_by_zero <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_qdiv_seq.sv
// tb_qdiv_seq: table, random and handshake checks of qdiv_seq against an arithmetic model
module tb_qdiv_seq;
  logic clk = 0, rst_n = 0, start = 0;
  logic [31:0] dividend = 0, divisor = 0, quotient;
  logic busy, done, overflow, div_by_zero;
  int tests = 0, fails = 0;
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic ov;
    logic dz;
  } vec_t;
  vec_t tbl[10];
  qdiv_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .overflow(overflow), .div_by_zero(div_by_zero)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // quotient = floor(|a| * 2^Q / |b|), saturated to 31 bits, sign-magnitude with no negative zero
  function automatic vec_t model(input logic [31:0] a, input logic [31:0] b);
    vec_t v;
    longint unsigned ma, mb, qq;
    ma = 64'(a[30:0]);
    mb = 64'(b[30:0]);
    v.a = a;
    v.b = b;
    v.ov = 1'b0;
    v.dz = 1'b0;
    if (mb == 0) begin
      v.dz = 1'b1;
      qq = 64'h7FFF_FFFF;
    end else begin
      qq = (ma << 15) / mb;
      if (qq > 64'h7FFF_FFFF) begin
        v.ov = 1'b1;
        qq = 64'h7FFF_FFFF;
      end
    end
    v.q = {(a[31] ^ b[31]) && qq != 0, qq[30:0]};
    return v;
  endfunction
  task automatic wait_done(output int n, output bit busy_ok, output bit stable);
    logic [31:0] q0;
    q0 = quotient;
    n = 0;
    busy_ok = 1;
    stable = 1;
    while (!done && n < 200) begin
      if (!busy) busy_ok = 0;
      if (quotient !== q0) stable = 0;
      @(posedge clk);
      #1;
      n++;
    end
    if (busy) busy_ok = 0;
  endtask
  task automatic run(input logic [31:0] a, input logic [31:0] b, output int n, output bit bo, output bit st);
    dividend = a;
    divisor = b;
    start = 1;
    @(posedge clk);
    #1 start = 0;
    dividend = $urandom;
    divisor = $urandom;
    wait_done(n, bo, st);
  endtask
  task automatic verify(input string tag, input vec_t e, input int n, input bit bo, input bit st);
    check({tag, ".quotient"}, 64'(quotient), 64'(e.q));
    check({tag, ".overflow"}, 64'(overflow), 64'(e.ov));
    check({tag, ".div_by_zero"}, 64'(div_by_zero), 64'(e.dz));
    check({tag, ".latency"}, 64'(n), e.dz ? 64'd0 : 64'd46);
    check({tag, ".busy"}, 64'(bo), 64'd1);
    check({tag, ".stable"}, 64'(st), 64'd1);
  endtask
  initial begin
    int n, cnt;
    bit bo, st;
    vec_t e;
    logic [31:0] a, b;
    tbl = '{
      '{32'h0001_8000, 32'h0001_0000, 32'h0000_C000, 1'b0, 1'b0},
      '{32'h8000_8000, 32'h0002_0000, 32'h8000_2000, 1'b0, 1'b0},
      '{32'h0000_8000, 32'h0001_8000, 32'h0000_2AAA, 1'b0, 1'b0},
      '{32'h4000_0000, 32'h0000_4000, 32'h7FFF_FFFF, 1'b1, 1'b0},
      '{32'h0000_8000, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1},
      '{32'h8000_0000, 32'h0000_8000, 32'h0000_0000, 1'b0, 1'b0},
      '{32'h0000_0001, 32'h7FFF_FFFF, 32'h0000_0000, 1'b0, 1'b0},
      '{32'h7FFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b0},
      '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_8000, 1'b0, 1'b0},
      '{32'h0000_0000, 32'h0000_0000, 32'h7FFF_FFFF, 1'b0, 1'b1}
    };
    repeat (3) @(posedge clk);
    #1;
    check("reset", 64'({busy, done, overflow, div_by_zero, quotient}), 64'd0);
    rst_n = 1;
    @(posedge clk);
    #1;
    foreach (tbl[i]) begin
      run(tbl[i].a, tbl[i].b, n, bo, st);
      verify($sformatf("vec%0d", i), tbl[i], n, bo, st);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d.done_pulse", i), 64'(done), 64'd0);
    end
    // consecutive random ops each start in the previous done cycle
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      b = $urandom;
      b[30:0] = b[30:0] >> $urandom_range(0, 30);
      if (i % 8 == 0) b[30:0] = '0;
      e = model(a, b);
      run(a, b, n, bo, st);
      verify($sformatf("rnd%0d", i), e, n, bo, st);
    end
    @(posedge clk);
    #1;
    // start pulsed mid-CALC with different operands
    e = model(32'h0001_8000, 32'h0001_0000);
    dividend = 32'h0001_8000;
    divisor = 32'h0001_0000;
    start = 1;
    @(posedge clk);
    #1 start = 0;
    repeat (10) @(posedge clk);
    #1 dividend = 32'h7FFF_FFFF;
    divisor = 32'h0000_0001;
    start = 1;
    @(posedge clk);
    #1 start = 0;
    wait_done(n, bo, st);
    verify("midstart", e, n + 11, bo, st);
    // start held during done: second op back-to-back
    run(32'h8000_8000, 32'h0002_0000, n, bo, st);
    verify("b2b", model(32'h8000_8000, 32'h0002_0000), n, bo, st);
    // reset mid-CALC
    dividend = 32'h0001_8000;
    divisor = 32'h0001_0000;
    start = 1;
    @(posedge clk);
    #1 start = 0;
    repeat (20) @(posedge clk);
    #1 rst_n = 0;
    #1;
    check("rst_mid", 64'({busy, done, overflow, div_by_zero, quotient}), 64'd0);
    cnt = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      cnt += int'(done | busy | (quotient != 0));
    end
    check("rst_hold", 64'(cnt), 64'd0);
    rst_n = 1;
    cnt = 0;
    repeat (50) begin
      @(posedge clk);
      #1;
      cnt += int'(done | busy);
    end
    check("rst_no_done", 64'(cnt), 64'd0);
    run(32'h0000_8000, 32'h0001_8000, n, bo, st);
    verify("post_rst", model(32'h0000_8000, 32'h0001_8000), n, bo, st);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
